// File: rtl/spi_dac_frame_receiver_if.sv
// Bundle of the DAC SPI lines and the deframed results of the receiver.
// The master drives the serial lines; the slave (the receiver) drives the results.
interface spi_dac_frame_receiver_if #(
    parameter int DATA_BITS = 12,
    parameter int CNT_W     = 16
) ();
    logic                 spi_cs;
    logic                 spi_sck;
    logic                 spi_mosi;
    logic [DATA_BITS-1:0] data_out;
    logic [1:0]           mode_out;
    logic                 data_valid;
    logic                 frame_err;
    logic [CNT_W-1:0]     frame_count;
    logic                 busy;

    modport master (
        output spi_cs, spi_sck, spi_mosi,
        input  data_out, mode_out, data_valid, frame_err, frame_count, busy
    );

    modport slave (
        input  spi_cs, spi_sck, spi_mosi,
        output data_out, mode_out, data_valid, frame_err, frame_count, busy
    );
endinterface

// File: rtl/spi_dac_frame_receiver.sv
// Oversampling SPI receiver for the DAC link: synchronizes cs/sck/mosi, deframes
// MSB-first words into mode + DAC code and flags frames with the wrong edge count.
module spi_dac_frame_receiver #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_dac_frame_receiver_if.slave  bus
);
    localparam int BW = $clog2(FRAME_BITS + 2);
    localparam logic [BW-1:0] BITS_FULL = BW'(FRAME_BITS);
    localparam logic [BW-1:0] BITS_SAT  = BW'(FRAME_BITS + 1);

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;

    logic cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_s3_q, cs_s3_d;
    logic sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_s3_q, sck_s3_d;
    logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;
    logic sck_fall_q, sck_fall_d, mosi_bit_q, mosi_bit_d;
    logic [1:0]            warm_q, warm_d;
    logic [1:0]            state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_out_q, data_out_d;
    logic [1:0]            mode_out_q, mode_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [CNT_W-1:0]      frame_count_q, frame_count_d;

    // Two-flop synchronizers, a third copy for edge detection, then a registered edge stage.
    always_comb begin
        cs_s1_d    = bus.spi_cs;
        cs_s2_d    = cs_s1_q;
        cs_s3_d    = cs_s2_q;
        sck_s1_d   = bus.spi_sck;
        sck_s2_d   = sck_s1_q;
        sck_s3_d   = sck_s2_q;
        mosi_s1_d  = bus.spi_mosi;
        mosi_s2_d  = mosi_s1_q;
        cs_rise_d  = cs_s2_q & ~cs_s3_q;
        cs_fall_d  = ~cs_s2_q & cs_s3_q;
        sck_fall_d = ~sck_s2_q & sck_s3_q;
        mosi_bit_d = mosi_s2_q;
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        mode_out_d    = mode_out_q;
        frame_count_d = frame_count_q;
        data_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        warm_d        = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;

        case (state_q)
            // The synchronizers restart at idle after reset; wait until they carry real
            // samples so a frame already running at reset release is never decoded.
            ST_WAIT_IDLE: begin
                if (warm_q == 2'd3 && cs_s2_q)
                    state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall_q) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_SHIFT: begin
                // A cs rise in the same sample as an sck fall closes the frame first.
                if (cs_rise_q) begin
                    state_d = ST_IDLE;
                    if (bit_cnt_q == BITS_FULL) begin
                        data_out_d    = shift_q[DATA_BITS-1:0];
                        mode_out_d    = shift_q[DATA_BITS+1:DATA_BITS];
                        data_valid_d  = 1'b1;
                        frame_count_d = frame_count_q + 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sck_fall_q) begin
                    if (bit_cnt_q < BITS_FULL)
                        shift_d = {shift_q[FRAME_BITS-2:0], mosi_bit_q};
                    if (bit_cnt_q != BITS_SAT)
                        bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s1_q       <= 1'b1;
            cs_s2_q       <= 1'b1;
            cs_s3_q       <= 1'b1;
            sck_s1_q      <= 1'b1;
            sck_s2_q      <= 1'b1;
            sck_s3_q      <= 1'b1;
            mosi_s1_q     <= 1'b0;
            mosi_s2_q     <= 1'b0;
            cs_rise_q     <= 1'b0;
            cs_fall_q     <= 1'b0;
            sck_fall_q    <= 1'b0;
            mosi_bit_q    <= 1'b0;
            warm_q        <= 2'd0;
            state_q       <= ST_WAIT_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            mode_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            cs_s1_q       <= cs_s1_d;
            cs_s2_q       <= cs_s2_d;
            cs_s3_q       <= cs_s3_d;
            sck_s1_q      <= sck_s1_d;
            sck_s2_q      <= sck_s2_d;
            sck_s3_q      <= sck_s3_d;
            mosi_s1_q     <= mosi_s1_d;
            mosi_s2_q     <= mosi_s2_d;
            cs_rise_q     <= cs_rise_d;
            cs_fall_q     <= cs_fall_d;
            sck_fall_q    <= sck_fall_d;
            mosi_bit_q    <= mosi_bit_d;
            warm_q        <= warm_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            mode_out_q    <= mode_out_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.mode_out    = mode_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_count = frame_count_q;
    assign bus.busy        = (state_q == ST_SHIFT);
endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Bench for spi_dac_frame_receiver: table of frames plus hand sequences, with a
// scoreboard queue of expected frame results checked when the DUT pulses.
module tb_spi_dac_frame_receiver;
    localparam int HALF = 5;   // sck half period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    spi_dac_frame_receiver_if bus ();

    spi_dac_frame_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        logic [11:0] data;
        logic [1:0]  mode;
        logic [15:0] count;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [31:0] word;
        int          nbits;
        bit          err;
        logic [11:0] data;
        logic [1:0]  mode;
        logic [15:0] count;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every data_valid / frame_err pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (bus.data_valid || bus.frame_err)) begin
            exp_t e;
            chk("pulse_exclusive", {31'd0, bus.data_valid & bus.frame_err}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.data_valid, bus.frame_err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("frame result: valid=%0b err=%0b data=%h mode=%0d count=%h",
                         bus.data_valid, bus.frame_err, bus.data_out, bus.mode_out, bus.frame_count);
                chk("frame_err", {31'd0, bus.frame_err}, {31'd0, e.err});
                chk("data_valid", {31'd0, bus.data_valid}, {31'd0, !e.err});
                chk("data_out", {20'd0, bus.data_out}, {20'd0, e.data});
                chk("mode_out", {30'd0, bus.mode_out}, {30'd0, e.mode});
                chk("frame_count", {16'd0, bus.frame_count}, {16'd0, e.count});
                chk("latency", cyc - e.cyc, 32'd4);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_mosi = w[i];
            repeat (HALF) @(negedge clk);
            bus.spi_sck = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.spi_sck = 1'b1;
        end
    endtask

    task automatic push_exp(input bit err, input logic [11:0] d, input logic [1:0] m,
                            input logic [15:0] c);
        exp_t e;
        e.err = err; e.data = d; e.mode = m; e.count = c; e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic send_frame(input logic [31:0] w, input int n, input bit err,
                              input logic [11:0] d, input logic [1:0] m,
                              input logic [15:0] c, input int gap);
        @(negedge clk);
        bus.spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(w, n);
        repeat (HALF) @(negedge clk);
        chk("busy_in_frame", {31'd0, bus.busy}, 32'd1);
        bus.spi_cs = 1'b1;
        push_exp(err, d, m, c);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_data_out"}, {20'd0, bus.data_out}, 32'd0);
        chk({tag, "_mode_out"}, {30'd0, bus.mode_out}, 32'd0);
        chk({tag, "_frame_count"}, {16'd0, bus.frame_count}, 32'd0);
        chk({tag, "_pulses"}, {30'd0, bus.data_valid, bus.frame_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0ABC,  16, 1'b0, 12'hABC, 2'd0, 16'd1};
        vecs[1] = '{32'h3FFF,  16, 1'b0, 12'hFFF, 2'd3, 16'd2};
        vecs[2] = '{32'h0123,  16, 1'b0, 12'h123, 2'd0, 16'd3};
        vecs[3] = '{32'h02AA,  10, 1'b1, 12'h123, 2'd0, 16'd3};
        vecs[4] = '{32'h0AAB,  17, 1'b1, 12'h123, 2'd0, 16'd3};
        vecs[5] = '{32'h0777,  16, 1'b0, 12'h777, 2'd0, 16'd4};
        vecs[6] = '{32'hC5A5,  16, 1'b0, 12'h5A5, 2'd0, 16'd5};
        vecs[7] = '{32'h0000,   0, 1'b1, 12'h5A5, 2'd0, 16'd5};

        bus.spi_cs = 1'b1;
        bus.spi_sck = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_cleared("post_reset");

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].word, vecs[i].nbits, vecs[i].err, vecs[i].data,
                       vecs[i].mode, vecs[i].count, 10);
            chk("busy_idle", {31'd0, bus.busy}, 32'd0);
        end

        // cs rise sampled together with the 16th sck fall: that edge is not counted
        @(negedge clk);
        bus.spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(32'h0088, 15);
        bus.spi_mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.spi_sck = 1'b0;
        bus.spi_cs = 1'b1;
        push_exp(1'b1, 12'h5A5, 2'd0, 16'd5);
        repeat (HALF) @(negedge clk);
        bus.spi_sck = 1'b1;
        repeat (10) @(negedge clk);

        // reset in the middle of a frame; the tail of that frame must be ignored
        bus.spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(32'h00AB, 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_cleared("mid_reset");
        send_bits(32'h00CD, 8);
        repeat (HALF) @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(32'h0123, 16, 1'b0, 12'h123, 2'd0, 16'd1, 10);

        // back-to-back frames with cs high for 3 clk cycles between them
        send_frame(32'h0001, 16, 1'b0, 12'h001, 2'd0, 16'd2, 2);
        send_frame(32'h0002, 16, 1'b0, 12'h002, 2'd0, 16'd3, 10);

        // preload the counter at its maximum and check the wrap
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        chk("preload_count", {16'd0, bus.frame_count}, 32'h0000FFFF);
        send_frame(32'h0ABC, 16, 1'b0, 12'hABC, 2'd0, 16'h0000, 10);
        send_frame(32'h1234, 16, 1'b0, 12'h234, 2'd1, 16'h0001, 10);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
